// File: rtl/rf_arb_pkg.sv
// Shared defaults for the register-file write arbiter slice.
package rf_arb_pkg;
  localparam int NUM_REQ_DEF = 2;
  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 32;
  localparam int RF_DEPTH    = 2 ** ADDR_W_DEF;

  // Round-robin successor of a requester index.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback requester bus plus register file write port and pending-write mask.
interface rf_write_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) ();
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      rgwr;
  logic [ADDR_W-1:0]         wrg;
  logic [DATA_W-1:0]         wdata;
  logic [2**ADDR_W-1:0]      pending;

  modport master (
    output req_valid, req_reg, req_data,
    input  req_ready, rgwr, wrg, wdata, pending
  );

  modport slave (
    input  req_valid, req_reg, req_data,
    output req_ready, rgwr, wrg, wdata, pending
  );
endinterface

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant, search starts at ptr and wraps upward.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);
  int idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (grant == '0 && req[idx]) grant[idx] = 1'b1;
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares one register file write port among NUM_REQ one-entry writeback buffers.
// Optional: RF_ZERO_REG_PROTECT_EN discards writes to register 0 after the handshake.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input logic                clk,
  input logic                rst,
  rf_write_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [NUM_REQ-1:0] hold_v;
  logic [ADDR_W-1:0]  hold_reg  [NUM_REQ];
  logic [DATA_W-1:0]  hold_data [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] load;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   g_idx;
  logic               rgwr;
  logic [ADDR_W-1:0]  wrg;
  logic [DATA_W-1:0]  wdata;
  logic [DEPTH-1:0]   pending;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (hold_v),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Ready depends only on registered state, never on req_valid.
  assign ready = ~hold_v | grant;

  always_comb begin
    g_idx = '0;
    load  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) g_idx = PTR_W'(i);
`ifdef RF_ZERO_REG_PROTECT_EN
      load[i] = bus.req_valid[i] && ready[i] && (bus.req_reg[i*ADDR_W +: ADDR_W] != '0);
`else
      load[i] = bus.req_valid[i] && ready[i];
`endif
    end
  end

  // A load in the same cycle as a grant wins, so the buffer stays valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is always updated with non-blocking assignments.
      hold_v <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load[i])       hold_v[i] <= 1'b1;
        else if (grant[i]) hold_v[i] <= 1'b0;
      end
    end
  end

  // NOTE: buffer payloads are qualified by hold_v, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (load[i]) begin
        hold_reg[i]  <= bus.req_reg[i*ADDR_W +: ADDR_W];
        hold_data[i] <= bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgwr   <= 1'b0;
      wrg    <= '0;
      wdata  <= '0;
      rr_ptr <= '0;
    end else if (|grant) begin
      rgwr   <= 1'b1;
      wrg    <= hold_reg[g_idx];
      wdata  <= hold_data[g_idx];
      rr_ptr <= PTR_W'(next_idx(int'(g_idx), NUM_REQ));
    end else begin
      rgwr <= 1'b0;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hold_v[i]) pending[hold_reg[i]] = 1'b1;
    end
    if (rgwr) pending[wrg] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign bus.rgwr      = rgwr;
  assign bus.wrg       = wrg;
  assign bus.wdata     = wdata;
  assign bus.pending   = pending;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter with a behavioural register file behind the write port.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] rf [RF_DEPTH];
  logic [1:0]  acc;
  logic [31:0] d0, d1;

  rf_write_arbiter_if #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(32)) bus ();

  rf_write_arbiter #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.rgwr) rf[bus.wrg] <= bus.wdata;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.req_valid[i]       = v;
    bus.req_reg[i*5 +: 5]  = r;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_reg   = '0;
    bus.req_data  = '0;

    // Reset state
    do_reset();
    check("rst_rgwr",    bus.rgwr,      0);
    check("rst_wrg",     bus.wrg,       0);
    check("rst_wdata",   bus.wdata,     0);
    check("rst_pending", bus.pending,   0);
    check("rst_ready",   bus.req_ready, 2'b11);

    // Single write: reg 5 <= DEADBEEF
    drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    bus.req_valid = '0;
    check("sw_pend_buf", bus.pending[5], 1);
    check("sw_rgwr0",    bus.rgwr,       0);
    tick();
    check("sw_rgwr1",    bus.rgwr,       1);
    check("sw_wrg",      bus.wrg,        5);
    check("sw_wdata",    bus.wdata,      32'hDEADBEEF);
    check("sw_pend_port", bus.pending[5], 1);
    tick();
    check("sw_rgwr_off", bus.rgwr,       0);
    check("sw_pend_clr", bus.pending,    0);
    check("sw_rf5",      rf[5],          32'hDEADBEEF);

    // Contention: requester data advances only on accepted transfers
    do_reset();
    d0 = 32'h100;
    d1 = 32'h200;
    drive(0, 1'b1, 5'd3, d0);
    drive(1, 1'b1, 5'd7, d1);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      acc = bus.req_valid & bus.req_ready;
      tick();
      if (acc[0]) begin d0++; drive(0, 1'b1, 5'd3, d0); end
      if (acc[1]) begin d1++; drive(1, 1'b1, 5'd7, d1); end
      if (cyc == 2) check("ct_ready_bp", bus.req_ready, 2'b10);
      if (cyc >= 2) begin
        check("ct_rgwr", bus.rgwr, 1);
        if (cyc % 2 == 0) begin
          check("ct_wrg0",   bus.wrg,   3);
          check("ct_wdata0", bus.wdata, 32'h100 + (cyc - 2) / 2);
        end else begin
          check("ct_wrg1",   bus.wrg,   7);
          check("ct_wdata1", bus.wdata, 32'h200 + (cyc - 3) / 2);
        end
      end
    end
    bus.req_valid = '0;

    // Backpressure: requester 1 keeps a new request waiting while its buffer is full
    do_reset();
    drive(0, 1'b1, 5'd4, 32'hA);
    drive(1, 1'b1, 5'd6, 32'hB);
    tick();
    bus.req_valid[0] = 1'b0;
    drive(1, 1'b1, 5'd6, 32'hC);
    check("bp_ready1_low", bus.req_ready[1], 0);
    tick();
    check("bp_wr_a",   bus.wdata, 32'hA);
    check("bp_ready1", bus.req_ready[1], 1);
    tick();
    bus.req_valid = '0;
    check("bp_wrg_b",  bus.wrg,   6);
    check("bp_wr_b",   bus.wdata, 32'hB);
    tick();
    check("bp_wr_c",   bus.wdata, 32'hC);

    // Same-register WAW in one cycle
    do_reset();
    drive(0, 1'b1, 5'd9, 32'd1);
    drive(1, 1'b1, 5'd9, 32'd2);
    tick();
    bus.req_valid = '0;
    check("waw_pend", bus.pending, 32'h200);
    tick();
    check("waw_first", bus.wdata, 1);
    tick();
    check("waw_second", bus.wdata, 2);
    check("waw_pend2",  bus.pending[9], 1);
    tick();
    check("waw_rf9",    rf[9], 2);
    check("waw_idle",   bus.pending, 0);

    // Register 0 handling
    do_reset();
    drive(0, 1'b1, 5'd0, 32'h55);
    check("z_ready", bus.req_ready[0], 1);
    tick();
    bus.req_valid = '0;
`ifdef RF_ZERO_REG_PROTECT_EN
    check("z_pend",  bus.pending[0], 0);
    check("z_ready2", bus.req_ready, 2'b11);
    tick();
    check("z_rgwr",  bus.rgwr, 0);
    check("z_pend2", bus.pending[0], 0);
`else
    check("z_pend",  bus.pending[0], 1);
    tick();
    check("z_rgwr",  bus.rgwr,  1);
    check("z_wrg",   bus.wrg,   0);
    check("z_wdata", bus.wdata, 32'h55);
`endif

    // Reset mid-stream with both buffers full and a write on the port
    do_reset();
    drive(0, 1'b1, 5'd12, 32'h12);
    drive(1, 1'b1, 5'd13, 32'h13);
    tick();
    tick();
    check("mr_pre_rgwr", bus.rgwr,   1);
    check("mr_pre_hold", bus.pending, 32'h3000);
    rst = 1'b1;
    #1;
    check("mr_rgwr",    bus.rgwr,    0);
    check("mr_pending", bus.pending, 0);
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
    check("mr_ready",   bus.req_ready, 2'b11);
    tick();
    check("mr_quiet",   bus.rgwr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
